// File: rtl/alu_top.sv
// alu_top: board-level wrapper around an 8-bit MIPS-style ALU.
// Three switch-loaded registers (A, B, opcode) feed a combinational ALU
// whose result drives the LEDs directly.
// Optional feature: define ALU_SLL_EN to add opcode 0x00 (SLL).
module alu_top #(
    parameter int N          = 8,
    parameter int N_OP       = 6,
    parameter int N_BUTTONS  = 3,
    parameter int N_SWITCHES = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_SWITCHES-1:0] i_switches,
    input  logic [N_BUTTONS-1:0]  i_buttons,
    output logic [N-1:0]          o_leds
);

    typedef enum logic [N_OP-1:0] {
        OP_SLL = N_OP'('h00),
        OP_SRL = N_OP'('h02),
        OP_SRA = N_OP'('h03),
        OP_ADD = N_OP'('h20),
        OP_SUB = N_OP'('h22),
        OP_AND = N_OP'('h24),
        OP_OR  = N_OP'('h25),
        OP_XOR = N_OP'('h26),
        OP_NOR = N_OP'('h27)
    } alu_op_e;

    logic [N-1:0]    reg_a_q,  reg_a_d;
    logic [N-1:0]    reg_b_q,  reg_b_d;
    logic [N_OP-1:0] reg_op_q, reg_op_d;
    logic            shift_oob;

    // Next-state for the input registers: each button independently loads the shared switches
    always_comb begin
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_op_d = reg_op_q;
        if (i_buttons[0]) reg_a_d  = i_switches[N-1:0];
        if (i_buttons[1]) reg_b_d  = i_switches[N-1:0];
        if (i_buttons[2]) reg_op_d = i_switches[N_OP-1:0];
    end

    // Input registers with synchronous reset taking priority over the buttons
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= '0;
        end else begin
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
        end
    end

    // Shift amount is the full unsigned value of B; anything >= N shifts everything out
    assign shift_oob = (int'(reg_b_q) >= N);

    // Combinational ALU; unsupported opcodes produce zero
    always_comb begin
        o_leds = '0;
        case (reg_op_q)
            OP_ADD: o_leds = reg_a_q + reg_b_q;
            OP_SUB: o_leds = reg_a_q - reg_b_q;
            OP_AND: o_leds = reg_a_q & reg_b_q;
            OP_OR:  o_leds = reg_a_q | reg_b_q;
            OP_XOR: o_leds = reg_a_q ^ reg_b_q;
            OP_NOR: o_leds = ~(reg_a_q | reg_b_q);
            OP_SRA: begin
                if (shift_oob) o_leds = {N{reg_a_q[N-1]}};
                else           o_leds = $signed(reg_a_q) >>> reg_b_q;
            end
            OP_SRL: begin
                if (shift_oob) o_leds = '0;
                else           o_leds = reg_a_q >> reg_b_q;
            end
`ifdef ALU_SLL_EN
            OP_SLL: begin
                if (shift_oob) o_leds = '0;
                else           o_leds = reg_a_q << reg_b_q;
            end
`endif
            default: o_leds = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top. Stimulus pushes expected LED
// values into a queue; a monitor pops and compares after each load.
module tb_alu_top;

    localparam int N = 8;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_switches = '0;
    logic [2:0] i_buttons = '0;
    logic [7:0] o_leds;

    alu_top #(.N(8), .N_OP(6), .N_BUTTONS(3), .N_SWITCHES(8)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_switches (i_switches),
        .i_buttons  (i_buttons),
        .o_leds     (o_leds)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    event     sample_ev;
    int       checks   = 0;
    int       failures = 0;

    // Independent reference model
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20: r = 8'((9'(a) + 9'(b)) % 256);
            6'h22: r = 8'((9'(a) + 9'(256) - 9'(b)) % 256);
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h03: begin
                r = a;
                for (int i = 0; i < int'(b); i++) r = {r[7], r[7:1]};
            end
            6'h02: begin
                r = a;
                for (int i = 0; i < int'(b); i++) r = {1'b0, r[7:1]};
            end
`ifdef ALU_SLL_EN
            6'h00: begin
                r = a;
                for (int i = 0; i < int'(b); i++) r = {r[6:0], 1'b0};
            end
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive one cycle of buttons/switches, then release the buttons
    task automatic press(input logic [2:0] btn, input logic [7:0] sw);
        @(negedge i_clock);
        i_switches = sw;
        i_buttons  = btn;
        @(posedge i_clock);
        #1;
        i_buttons = 3'b000;
    endtask

    task automatic expect_leds(input string name, input logic [7:0] exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb_q.push_back(it);
        ->sample_ev;
        #2;
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        press(3'b001, a);
        press(3'b010, b);
        press(3'b100, {2'b00, op});
    endtask

    // Monitor: whenever a result is announced, compare every queued expectation
    initial begin
        sb_item_t it;
        forever begin
            @(sample_ev);
            #1;
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check_val(it.name, o_leds, it.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops [10];
        logic [7:0] ra, rb;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02, 6'h3F, 6'h00};

        // Reset for two cycles, no buttons
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        expect_leds("reset_during", 8'h00);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        expect_leds("reset_after", 8'h00);
        check_val("reset_reg_a", dut.reg_a_q, 8'h00);
        check_val("reset_reg_b", dut.reg_b_q, 8'h00);
        check_val("reset_reg_op", {2'b00, dut.reg_op_q}, 8'h00);

        // Arithmetic
        load3(8'h7F, 8'h01, 6'h20); expect_leds("add_wrap", 8'h80);
        load3(8'h05, 8'h07, 6'h22); expect_leds("sub_wrap", 8'hFE);

        // Logic
        load3(8'h0F, 8'h3C, 6'h24); expect_leds("and", 8'h0C);
        press(3'b100, 8'h25);       expect_leds("or", 8'h3F);
        press(3'b100, 8'h26);       expect_leds("xor", 8'h33);
        press(3'b100, 8'h27);       expect_leds("nor", 8'hC0);

        // Opcode 0x00: SLL only when enabled
`ifdef ALU_SLL_EN
        load3(8'h0F, 8'h01, 6'h00); expect_leds("op00", 8'h1E);
`else
        load3(8'h0F, 8'h01, 6'h00); expect_leds("op00", 8'h00);
`endif

        // Shifts
        load3(8'h90, 8'h02, 6'h03); expect_leds("sra_2", 8'hE4);
        press(3'b100, 8'h02);       expect_leds("srl_2", 8'h24);
        press(3'b010, 8'h09);       expect_leds("srl_9", 8'h00);
        press(3'b100, 8'h03);       expect_leds("sra_9", 8'hFF);
        press(3'b010, 8'h08);       expect_leds("sra_8", 8'hFF);
        press(3'b010, 8'h07);       expect_leds("sra_7", 8'hFF);
        press(3'b001, 8'h40);       expect_leds("sra_7_pos", 8'h00);

        // Load timing: switches alone change nothing
        load3(8'h05, 8'h07, 6'h26); expect_leds("xor_pre", 8'h02);
        @(negedge i_clock);
        i_switches = 8'h22;
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        expect_leds("sw_no_button", 8'h02);
        press(3'b100, 8'h22);       expect_leds("op_load_edge", 8'hFE);

        // Two buttons at once
        press(3'b011, 8'h33);       expect_leds("ab_same_sub", 8'h00);
        check_val("ab_same_reg_a", dut.reg_a_q, 8'h33);
        check_val("ab_same_reg_b", dut.reg_b_q, 8'h33);
        press(3'b100, 8'h25);       expect_leds("ab_same_or", 8'h33);

        // All three buttons load the same value
        press(3'b111, 8'h24);       expect_leds("all_btn_and", 8'h24);

        // Held button reloads every cycle
        @(negedge i_clock);
        i_buttons  = 3'b001;
        i_switches = 8'h11;
        @(posedge i_clock);
        @(negedge i_clock);
        i_switches = 8'h66;
        @(posedge i_clock);
        #1;
        i_buttons = 3'b000;
        expect_leds("held_reload", 8'h24);   // 0x66 & 0x24
        check_val("held_reg_a", dut.reg_a_q, 8'h66);

        // Reset beats buttons
        @(negedge i_clock);
        i_reset    = 1'b1;
        i_buttons  = 3'b111;
        i_switches = 8'h20;
        @(posedge i_clock);
        #1;
        expect_leds("reset_prio", 8'h00);
        check_val("reset_prio_reg_a", dut.reg_a_q, 8'h00);
        @(negedge i_clock);
        i_reset   = 1'b0;
        i_buttons = 3'b000;

        // Randomised A/B per opcode against the reference model
        foreach (ops[k]) begin
            for (int j = 0; j < 10; j++) begin
                ra = 8'($urandom_range(0, 255));
                rb = (j < 2) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
                load3(ra, rb, ops[k]);
                expect_leds($sformatf("rand_op%02h_a%02h_b%02h", ops[k], ra, rb),
                            ref_alu(ra, rb, ops[k]));
            end
        end

        #20;
        check_val("sb_drained", 8'(sb_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
